// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with one word per
// line. Read hits complete combinationally; read misses and all writes stall
// the pipeline while the request is forwarded to dmem. Counts read hits and
// memory transactions (read misses plus writes).
module dcache_wt #(
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        mem_ReadEnable,
    output logic        mem_WriteEnable,
    output logic [31:0] mem_Address,
    output logic [31:0] mem_WriteData,
    input  logic [31:0] mem_ReadData,
    input  logic        mem_done,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int LINES = 2 ** INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [TAG_BITS-1:0] tag_d  [LINES];
    logic [31:0]         data_q [LINES];
    logic [31:0]         data_d [LINES];

    logic        rd_en_q, rd_en_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] fill_q, fill_d;
    // Set after the first cycle of a wait state so a stale mem_done level
    // left over from the previous transaction is not mistaken for completion.
    logic        armed_q, armed_d;
    logic        was_rd_q, was_rd_d;
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    logic [INDEX_BITS-1:0] req_idx, lat_idx;
    logic [TAG_BITS-1:0]   req_tag, lat_tag;
    logic                  req_hit, lat_hit;
    logic                  unused_addr_bits;

    assign req_idx = Address[INDEX_BITS+1:2];
    assign req_tag = Address[31:INDEX_BITS+2];
    assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    assign lat_idx = addr_q[INDEX_BITS+1:2];
    assign lat_tag = addr_q[31:INDEX_BITS+2];
    assign lat_hit = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);

    assign unused_addr_bits = ^Address[1:0];

    assign mem_ReadEnable  = rd_en_q;
    assign mem_WriteEnable = wr_en_q;
    assign mem_Address     = addr_q;
    assign mem_WriteData   = wdata_q;
    assign hit_count       = hit_cnt_q;
    assign miss_count      = miss_cnt_q;

    // Pipeline-facing outputs: same-cycle hit data and stall decision.
    always_comb begin
        Stall    = 1'b0;
        ReadData = '0;
        case (state_q)
            IDLE: begin
                if (MemWrite) begin
                    Stall = 1'b1;
                end else if (MemRead) begin
                    if (req_hit) begin
                        ReadData = data_q[req_idx];
                    end else begin
                        Stall = 1'b1;
                    end
                end
            end
            RD_MISS, WR_THRU: Stall = 1'b1;
            DONE: begin
                if (was_rd_q) begin
                    ReadData = fill_q;
                end
            end
            default: ;
        endcase
    end

    // Next-state logic for the controller, line storage and counters.
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        tag_d      = tag_q;
        data_d     = data_q;
        rd_en_d    = rd_en_q;
        wr_en_d    = wr_en_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        fill_d     = fill_q;
        armed_d    = armed_q;
        was_rd_d   = was_rd_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        case (state_q)
            IDLE: begin
                if (MemWrite) begin
                    addr_d   = Address;
                    wdata_d  = WriteData;
                    wr_en_d  = 1'b1;
                    was_rd_d = 1'b0;
                    armed_d  = 1'b0;
                    state_d  = WR_THRU;
                end else if (MemRead) begin
                    if (req_hit) begin
                        hit_cnt_d = hit_cnt_q + 32'd1;
                    end else begin
                        addr_d   = Address;
                        rd_en_d  = 1'b1;
                        was_rd_d = 1'b1;
                        armed_d  = 1'b0;
                        state_d  = RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                armed_d = 1'b1;
                if (armed_q && mem_done) begin
                    valid_d[lat_idx] = 1'b1;
                    tag_d[lat_idx]   = lat_tag;
                    data_d[lat_idx]  = mem_ReadData;
                    fill_d           = mem_ReadData;
                    rd_en_d          = 1'b0;
                    miss_cnt_d       = miss_cnt_q + 32'd1;
                    state_d          = DONE;
                end
            end
            WR_THRU: begin
                armed_d = 1'b1;
                if (armed_q && mem_done) begin
                    if (lat_hit) begin
                        data_d[lat_idx] = wdata_q;
                    end
                    wr_en_d    = 1'b0;
                    miss_cnt_d = miss_cnt_q + 32'd1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any in-flight transaction. Line tags and
    // data need no reset because every line is invalid afterwards.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            fill_q     <= '0;
            armed_q    <= 1'b0;
            was_rd_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            data_q     <= data_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            fill_q     <= fill_d;
            armed_q    <= armed_d;
            was_rd_q   <= was_rd_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

endmodule
